// File: rtl/modulator_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : modulator_axi_pkg
// Description : Shared constants for the PWM modulator AXI4-Lite slice:
//               register word offsets, response code, CTRL enable bit
//               position, register reset values and the byte-strobe merge
//               helper used by the register file.
// Revision    : 1.0 - initial release
// ============================================================================
package modulator_axi_pkg;

    // Word offsets (address bits [3:2]) of the control registers
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PERIOD  = 2'd1;
    localparam logic [1:0] REG_DUTY    = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    localparam int CTRL_EN_BIT = 0;

    localparam logic [31:0] CTRL_RST    = 32'h0000_0000;
    localparam logic [31:0] PERIOD_RST  = 32'h0000_0000;
    localparam logic [31:0] DUTY_RST    = 32'h0000_0000;
    localparam logic [31:0] SCRATCH_RST = 32'h0000_0000;

    // Replace only the bytes whose strobe bit is set
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/modulator_pwm_core.sv
`default_nettype none
// ============================================================================
// Module      : modulator_pwm_core
// Description : Free-running PWM counter with shadowed PERIOD/DUTY.
//               Shadows reload only at counter wrap or while disabled, so a
//               register update never produces a truncated/extended pulse.
// Ports       : clk, rst        - clock, async active-high reset
//               i_enable        - CTRL enable bit
//               i_period/i_duty - live PERIOD/DUTY register values
//               o_pwm_out       - registered PWM output
// Revision    : 1.0 - initial release
// ============================================================================
module modulator_pwm_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic [31:0] i_period,
    input  logic [31:0] i_duty,
    output logic        o_pwm_out
);

    logic [31:0] r_cnt;
    logic [31:0] r_period_sh;
    logic [31:0] r_duty_sh;
    logic        r_cmp;
    logic        r_pwm;
    logic        w_wrap;

    // A zero period wraps every cycle, which keeps cnt at 0 and lets the
    // shadows pick up a new PERIOD immediately.
    assign w_wrap = (r_period_sh == 32'd0) || (r_cnt >= r_period_sh - 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 32'd0;
            r_period_sh <= 32'd0;
            r_duty_sh   <= 32'd0;
            r_cmp       <= 1'b0;
            r_pwm       <= 1'b0;
        end else if (!i_enable) begin
            r_cnt       <= 32'd0;
            r_period_sh <= i_period;
            r_duty_sh   <= i_duty;
            r_cmp       <= 1'b0;
            r_pwm       <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_cnt       <= 32'd0;
                r_period_sh <= i_period;
                r_duty_sh   <= i_duty;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
            // Compare stage then output stage: output is a clean register
            r_cmp <= (r_period_sh != 32'd0) && (r_cnt < r_duty_sh);
            r_pwm <= r_cmp;
        end
    end

    assign o_pwm_out = r_pwm;

endmodule
`default_nettype wire

// File: rtl/modulator_axi_slave.sv
`default_nettype none
// ============================================================================
// Module      : modulator_axi_slave
// Description : AXI4-Lite slave owning the PWM modulator registers
//               (CTRL, PERIOD, DUTY, SCRATCH) and driving pwm_out.
// Ports       : ACLK, ARESET      - clock, async active-high reset
//               S_AXI_AW*/W*/B*   - write address/data/response channels
//               S_AXI_AR*/R*      - read address/data channels
//               pwm_out           - modulated output
// Revision    : 1.0 - initial release
// ============================================================================
module modulator_axi_slave
    import modulator_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            pwm_out
);

    logic [31:0] r_regs [4];

    logic        r_awready, r_wready, r_bvalid;
    logic        r_aw_held, r_w_held;
    logic [1:0]  r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    logic        r_arready, r_rvalid;
    logic [31:0] r_rdata;

    logic        w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic        w_commit;
    logic [1:0]  w_wr_idx;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic        w_unused;

    assign w_aw_hs = S_AXI_AWVALID && r_awready;
    assign w_w_hs  = S_AXI_WVALID  && r_wready;
    assign w_b_hs  = r_bvalid      && S_AXI_BREADY;
    assign w_ar_hs = S_AXI_ARVALID && r_arready;
    assign w_r_hs  = r_rvalid      && S_AXI_RREADY;

    // Commit as soon as both halves are available, taking each half either
    // from its holding register or straight from the bus this cycle.
    assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_wr_idx = r_aw_held ? r_awaddr : S_AXI_AWADDR[3:2];
    assign w_wdata  = r_w_held  ? r_wdata  : S_AXI_WDATA;
    assign w_wstrb  = r_w_held  ? r_wstrb  : S_AXI_WSTRB;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write channel and register file
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= 2'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_regs[REG_CTRL]    <= CTRL_RST;
            r_regs[REG_PERIOD]  <= PERIOD_RST;
            r_regs[REG_DUTY]    <= DUTY_RST;
            r_regs[REG_SCRATCH] <= SCRATCH_RST;
        end else begin
            if (w_aw_hs) begin
                r_awready <= 1'b0;
                r_awaddr  <= S_AXI_AWADDR[3:2];
            end
            if (w_w_hs) begin
                r_wready <= 1'b0;
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_regs[w_wr_idx] <= apply_wstrb(r_regs[w_wr_idx], w_wdata, w_wstrb);
            end else begin
                if (w_aw_hs) r_aw_held <= 1'b1;
                if (w_w_hs)  r_w_held  <= 1'b1;
            end
            // Ready stays low from its own handshake until the response is taken
            if (w_b_hs) begin
                r_bvalid  <= 1'b0;
                r_awready <= 1'b1;
                r_wready  <= 1'b1;
            end
        end
    end

    // Read channel: one outstanding read, data captured at AR handshake
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
        end else if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= r_regs[S_AXI_ARADDR[3:2]];
        end else if (w_r_hs) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = RESP_OKAY;

    modulator_pwm_core u_pwm_core (
        .clk       (ACLK),
        .rst       (ARESET),
        .i_enable  (r_regs[REG_CTRL][CTRL_EN_BIT]),
        .i_period  (r_regs[REG_PERIOD]),
        .i_duty    (r_regs[REG_DUTY]),
        .o_pwm_out (pwm_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_modulator_axi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_modulator_axi_slave
// Description : Self-checking bench for modulator_axi_slave. Stimulus tasks
//               push expected B/R responses into queues; a monitor pops and
//               compares whenever a response handshake is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modulator_axi_slave;

    logic        tb_ACLK;
    logic        tb_ARESET;
    logic [3:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        pwm_out;

    int total = 0;
    int bad   = 0;

    logic [1:0]  exp_b [$];
    logic [31:0] exp_r [$];

    // PWM run-length record: level and length of each completed run
    logic        run_lvl [$];
    int          run_len [$];
    logic        cur_lvl = 1'b0;
    int          cur_len = 0;

    modulator_axi_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4)
    ) dut (
        .ACLK          (tb_ACLK),
        .ARESET        (tb_ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .pwm_out       (pwm_out)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge tb_ACLK) begin
        if (!tb_ARESET) begin
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (exp_b.size() == 0) check("unexpected_b", 32'd1, 32'd0);
                else check("bresp", {30'd0, S_AXI_BRESP}, {30'd0, exp_b.pop_front()});
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (exp_r.size() == 0) check("unexpected_r", 32'd1, 32'd0);
                else begin
                    check("rdata", S_AXI_RDATA, exp_r.pop_front());
                    check("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
                end
            end
        end
    end

    // PWM run-length monitor
    always @(negedge tb_ACLK) begin
        if (pwm_out === cur_lvl) cur_len++;
        else begin
            run_lvl.push_back(cur_lvl);
            run_len.push_back(cur_len);
            cur_lvl = pwm_out;
            cur_len = 1;
        end
    end

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int  n;
        logic aw_go, w_go;
        @(posedge tb_ACLK); #1;
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        exp_b.push_back(2'b00);
        n = 0;
        while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 50) begin
            @(negedge tb_ACLK);
            aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
            w_go  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge tb_ACLK); #1;
            if (aw_go) S_AXI_AWVALID = 1'b0;
            if (w_go)  S_AXI_WVALID  = 1'b0;
            n++;
        end
        check("write_accept_timeout", {31'd0, S_AXI_AWVALID || S_AXI_WVALID}, 32'd0);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
        int  n;
        logic go;
        @(posedge tb_ACLK); #1;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        exp_r.push_back(exp);
        n = 0;
        while (S_AXI_ARVALID && n < 50) begin
            @(negedge tb_ACLK);
            go = S_AXI_ARREADY;
            @(posedge tb_ACLK); #1;
            if (go) S_AXI_ARVALID = 1'b0;
            n++;
        end
        check("read_accept_timeout", {31'd0, S_AXI_ARVALID}, 32'd0);
        S_AXI_ARVALID = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 200) begin
            @(negedge tb_ACLK);
            n++;
        end
        check("drain_timeout", exp_b.size() + exp_r.size(), 32'd0);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        axi_write(addr, data, 4'hF);
        drain();
    endtask

    task automatic rd(input logic [3:0] addr, input logic [31:0] exp);
        axi_read(addr, exp);
        drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, {31'd0, S_AXI_AWREADY}, 32'd1);
        check({tag, "_wready"},  {31'd0, S_AXI_WREADY},  32'd1);
        check({tag, "_arready"}, {31'd0, S_AXI_ARREADY}, 32'd1);
        check({tag, "_bvalid"},  {31'd0, S_AXI_BVALID},  32'd0);
        check({tag, "_rvalid"},  {31'd0, S_AXI_RVALID},  32'd0);
        check({tag, "_rdata"},   S_AXI_RDATA,            32'd0);
        check({tag, "_resp"},    {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
        check({tag, "_pwm"},     {31'd0, pwm_out},       32'd0);
    endtask

    task automatic wait_pwm(input logic lvl);
        int n = 0;
        while (pwm_out !== lvl && n < 40) begin
            @(negedge tb_ACLK);
            n++;
        end
        check("pwm_wait_timeout", {31'd0, pwm_out}, {31'd0, lvl});
    endtask

    initial begin
        int highs;
        tb_ARESET = 1'b1;
        S_AXI_AWADDR = 4'd0; S_AXI_AWPROT = 3'd0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'd0; S_AXI_WSTRB = 4'd0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b1;
        S_AXI_ARADDR = 4'd0; S_AXI_ARPROT = 3'd0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1;
        #3;
        check_reset_outputs("reset");
        @(posedge tb_ACLK); #1;
        tb_ARESET = 1'b0;

        // Full-register write/readback
        wr(4'h0, 32'h0101FFFF);
        wr(4'h4, 32'hABCD0001);
        wr(4'h8, 32'hDEAD0011);
        wr(4'hC, 32'hBEEF0011);
        rd(4'h0, 32'h0101FFFF);
        rd(4'h4, 32'hABCD0001);
        rd(4'h8, 32'hDEAD0011);
        rd(4'hC, 32'hBEEF0011);

        // W ahead of AW with partial strobe
        @(posedge tb_ACLK); #1;
        S_AXI_WDATA = 32'hFFFFFFFF; S_AXI_WSTRB = 4'b0011; S_AXI_WVALID = 1'b1;
        exp_b.push_back(2'b00);
        @(negedge tb_ACLK);
        check("wready_before_w", {31'd0, S_AXI_WREADY}, 32'd1);
        @(posedge tb_ACLK); #1;
        S_AXI_WVALID = 1'b0;
        @(negedge tb_ACLK);
        check("wready_low_after_w", {31'd0, S_AXI_WREADY}, 32'd0);
        check("no_bvalid_without_aw", {31'd0, S_AXI_BVALID}, 32'd0);
        repeat (2) @(posedge tb_ACLK);
        #1;
        S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
        @(negedge tb_ACLK);
        check("awready_while_w_held", {31'd0, S_AXI_AWREADY}, 32'd1);
        @(posedge tb_ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        @(negedge tb_ACLK);
        check("bvalid_after_aw", {31'd0, S_AXI_BVALID}, 32'd1);
        drain();
        rd(4'hC, 32'hBEEFFFFF);

        // Response backpressure on both channels
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        fork
            axi_write(4'hC, 32'h12345678, 4'hF);
            axi_read(4'h8, 32'hDEAD0011);
        join
        for (int i = 0; i < 5; i++) begin
            @(negedge tb_ACLK);
            check("hold_bvalid",  {31'd0, S_AXI_BVALID},  32'd1);
            check("hold_rvalid",  {31'd0, S_AXI_RVALID},  32'd1);
            check("hold_rdata",   S_AXI_RDATA,            32'hDEAD0011);
            check("hold_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
            check("hold_wready",  {31'd0, S_AXI_WREADY},  32'd0);
            check("hold_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
        end
        @(posedge tb_ACLK); #1;
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        drain();
        @(posedge tb_ACLK); #1;
        check("awready_back", {31'd0, S_AXI_AWREADY}, 32'd1);
        check("arready_back", {31'd0, S_AXI_ARREADY}, 32'd1);
        rd(4'hC, 32'h12345678);

        // Same-register read and write in one cycle: read sees old value
        fork
            axi_write(4'hC, 32'hCAFEF00D, 4'hF);
            axi_read(4'hC, 32'h12345678);
        join
        drain();
        rd(4'hC, 32'hCAFEF00D);

        // PWM: PERIOD=10, DUTY=3
        wr(4'h0, 32'h0);
        wr(4'h4, 32'd10);
        wr(4'h8, 32'd3);
        wr(4'h0, 32'h1);
        repeat (25) @(negedge tb_ACLK);
        run_lvl.delete(); run_len.delete();
        repeat (40) @(negedge tb_ACLK);
        check("pwm_run_count", {31'd0, run_len.size() >= 5}, 32'd1);
        for (int i = 1; i < 5 && i < run_len.size(); i++)
            check(run_lvl[i] ? "pwm_high_run_d3" : "pwm_low_run_d3", run_len[i], run_lvl[i] ? 32'd3 : 32'd7);

        // DUTY=7 written just after a pulse ends: current period keeps DUTY=3
        wait_pwm(1'b1);
        wait_pwm(1'b0);
        @(negedge tb_ACLK);
        run_lvl.delete(); run_len.delete();
        wr(4'h8, 32'd7);
        repeat (40) @(negedge tb_ACLK);
        check("pwm_run_count2", {31'd0, run_len.size() >= 4}, 32'd1);
        for (int i = 0; i < 4 && i < run_len.size(); i++) begin
            check("pwm_run_level", {31'd0, run_lvl[i]}, (i % 2 == 0) ? 32'd0 : 32'd1);
            check("pwm_run_d7", run_len[i], (i % 2 == 0) ? ((i == 0) ? 32'd7 : 32'd3) : 32'd7);
        end

        // PERIOD=0 keeps output low
        wr(4'h0, 32'h0);
        wr(4'h4, 32'd0);
        wr(4'h8, 32'd3);
        wr(4'h0, 32'h1);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge tb_ACLK);
            if (pwm_out) highs++;
        end
        check("pwm_period0_highs", highs, 32'd0);

        // DUTY >= PERIOD gives constant high
        wr(4'h8, 32'd12);
        wr(4'h4, 32'd10);
        repeat (5) @(negedge tb_ACLK);
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge tb_ACLK);
            if (pwm_out) highs++;
        end
        check("pwm_duty_ge_period_highs", highs, 32'd30);

        // Reset between AW and W handshakes
        @(posedge tb_ACLK); #1;
        S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
        @(negedge tb_ACLK);
        @(posedge tb_ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        @(negedge tb_ACLK);
        check("aw_only_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
        check("aw_only_wready",  {31'd0, S_AXI_WREADY},  32'd1);
        #2;
        tb_ARESET = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(posedge tb_ACLK); #1;
        tb_ARESET = 1'b0;
        wr(4'h4, 32'h00000020);
        rd(4'h4, 32'h00000020);
        rd(4'h0, 32'h00000000);
        rd(4'hC, 32'h00000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
